// File: rtl/elastic_pipe.sv
// elastic_pipe: multi-stage elastic pipeline register with valid/ready at
// both ends, bubble collapse, synchronous flush and an occupancy count.
//
// Handshake semantics: a word moves across an interface on a rising edge
// where valid && ready are both high.  in_ready depends only on the
// downstream stage state, out_ready and flush.  It never depends on in_valid.
// out_valid never depends on out_ready.  While out_valid is high and
// out_ready is low, out_data is held stable.  flush suppresses both
// interfaces for that cycle.
module elastic_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  // Stage 0 is the input side, stage DEPTH-1 the output side.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // r[i] = stage i may load this cycle.  r[DEPTH] is the downstream ready.
  logic [DEPTH:0]   r;
  logic             acc;
  logic             hs;

  // Ready chain.  r[i] = !v[i] || r[i+1] is unrolled into "out_ready, or any
  // stage from i to the output is empty".  This avoids a self-referencing
  // vector.
  always_comb begin
    logic any_free;
    r = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      any_free = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        any_free = any_free | ~v[j];
      end
      r[i] = any_free;
    end
  end

  // Interface signals and the accept and handshake strobes.
  always_comb begin
    in_ready  = r[0] & ~flush;
    out_valid = v[DEPTH-1] & ~flush;
    out_data  = d[DEPTH-1];
    acc       = in_valid & in_ready;
    hs        = out_valid & out_ready;
  end

  // Stage registers.  A stage with r[i] set takes its source.  An empty
  // source leaves a bubble, which is cleared.  A stage without r[i] holds.
  // A flush drops every valid bit and leaves the data registers as they are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (r[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

  // Occupancy.  Add 1 on an accept, subtract 1 on a handshake, and clear on
  // a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(acc) - CW'(hs);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe.  A DEPTH=4 and a DEPTH=1 instance share one
// stimulus stream.  Each instance is compared every cycle against a
// word-position reference model.  The DEPTH=4 output order is also checked
// against a queue of the accepted words.
module tb_elastic_pipe;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         out_ready;
  logic         flush;
  logic [W-1:0] in_data;

  logic         ir4, ov4, ir1, ov1;
  logic [W-1:0] od4, od1;
  logic [2:0]   cnt4;
  logic [0:0]   cnt1;

  int vectors     = 0;
  int miscompares = 0;

  elastic_pipe #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .flush(flush), .count(cnt4)
  );

  elastic_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .flush(flush), .count(cnt1)
  );

  // ---------------- reference model ----------------
  // Each word in flight is stored with the instance that holds it and its
  // stage position.  Entries of one instance are kept oldest first.
  typedef struct {
    int           inst;
    logic [W-1:0] d;
    int           p;
  } word_t;

  word_t        mq[$];
  logic [W-1:0] exp_q[$];
  int           depth_of[2] = '{4, 1};

  function automatic int msize(int inst);
    int n = 0;
    foreach (mq[i]) if (mq[i].inst == inst) n++;
    return n;
  endfunction

  function automatic int mhead(int inst);
    foreach (mq[i]) if (mq[i].inst == inst) return i;
    return -1;
  endfunction

  function automatic logic exp_in_ready(int inst);
    return !flush && ((msize(inst) < depth_of[inst]) || out_ready);
  endfunction

  function automatic logic exp_out_valid(int inst);
    int h;
    h = mhead(inst);
    if (flush || h < 0) return 1'b0;
    return (mq[h].p == depth_of[inst] - 1);
  endfunction

  task automatic mclear(int inst);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].inst == inst) mq.delete(i);
  endtask

  // Advance one instance by one edge.  A word moves forward one slot when
  // the output is being drained or when a free slot exists ahead of it.
  // A word that passes the last slot leaves the pipeline.
  task automatic mstep(int inst);
    int   dep;
    int   k;
    logic acc;
    dep = depth_of[inst];
    k   = 0;
    if (flush) begin
      mclear(inst);
    end else begin
      acc = in_valid && ((msize(inst) < dep) || out_ready);
      foreach (mq[i]) begin
        if (mq[i].inst == inst) begin
          if (out_ready || (k < dep - 1 - mq[i].p)) mq[i].p++;
          k++;
        end
      end
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].inst == inst && mq[i].p == dep) mq.delete(i);
      if (acc) mq.push_back('{inst: inst, d: in_data, p: 0});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(int inst, logic ir, logic ov, logic [W-1:0] od,
                            logic [31:0] cnt);
    string s;
    int    h;
    logic  ev;
    s  = (inst == 0) ? "d4" : "d1";
    h  = mhead(inst);
    ev = exp_out_valid(inst);
    chk({s, ".in_ready"}, 32'(ir), 32'(exp_in_ready(inst)));
    chk({s, ".out_valid"}, 32'(ov), 32'(ev));
    chk({s, ".count"}, cnt, 32'(msize(inst)));
    if (ev) chk({s, ".out_data"}, 32'(od), 32'(mq[h].d));
  endtask

  task automatic check_all();
    check_inst(0, ir4, ov4, od4, 32'(cnt4));
    check_inst(1, ir1, ov1, od1, 32'(cnt1));
    if (exp_out_valid(0) && out_ready && exp_q.size() > 0)
      chk("d4.order", 32'(od4), 32'(exp_q.pop_front()));
    if (exp_in_ready(0) && in_valid) exp_q.push_back(in_data);
  endtask

  // ---------------- driver ----------------
  // Drive inputs just after a rising edge.  Check on the falling edge.
  // Advance the model on the next rising edge.
  task automatic cyc(logic iv, logic [W-1:0] dat, logic ordy, logic fl);
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
    end else begin
      mstep(0);
      mstep(1);
      if (fl) exp_q.delete();
    end
    #1;
  endtask

  task automatic idle(int n, logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state
    cyc(1'b1, 16'h1234, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst.od4", 32'(od4), 32'h0);
    chk("rst.od1", 32'(od1), 32'h0);
    chk("rst.cnt4", 32'(cnt4), 32'h0);
    rst_n = 1'b1;

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Backpressure: only four words fit
    for (int i = 0; i < 6; i++) cyc(1'b1, W'(16'h00A0 + i), 1'b0, 1'b0);
    idle(10, 1'b0);
    chk("s2.count4", 32'(cnt4), 32'd4);
    chk("s2.hold4", 32'(od4), 32'h00A0);
    chk("s2.in_ready4", 32'(ir4), 32'h0);

    // Full pipeline streaming through
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h00B0 + i), 1'b1, 1'b0);
    idle(8, 1'b1);

    // Bubble collapse
    cyc(1'b1, 16'h0055, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 16'h0066, 1'b0, 1'b0);
    chk("s4.count4", 32'(cnt4), 32'd2);
    chk("s4.head4", 32'(od4), 32'h0055);
    chk("s4.valid4", 32'(ov4), 32'h1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Flush with words in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(16'h00C0 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h00C3, 1'b0, 1'b1);
    chk("s5.ov4", 32'(ov4), 32'h0);
    chk("s5.cnt4", 32'(cnt4), 32'h0);
    cyc(1'b1, 16'h00C4, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Randomised traffic with alternating backpressure phases
    for (int i = 0; i < 400; i++) begin
      logic ordy;
      if (((i / 40) % 2) == 1) ordy = ($urandom_range(0, 3) == 0);
      else                     ordy = ($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 1)), W'($urandom), ordy,
          ($urandom_range(0, 31) == 0));
    end
    idle(6, 1'b1);

    // Asynchronous reset between edges with words in flight
    cyc(1'b1, 16'h00D0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00D1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("s7.pre_ov4", 32'(ov4), 32'h1);
    chk("s7.pre_cnt4", 32'(cnt4), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7.ov4", 32'(ov4), 32'h0);
    chk("s7.cnt4", 32'(cnt4), 32'h0);
    chk("s7.od4", 32'(od4), 32'h0);
    chk("s7.ov1", 32'(ov1), 32'h0);
    chk("s7.cnt1", 32'(cnt1), 32'h0);
    mq.delete();
    exp_q.delete();
    idle(2, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(16'h00E0 + i), 1'b1, 1'b0);
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
